// File: rtl/gate_response_checker.sv
// Gate response checker: steps a 4-input gate unit through all 16 input
// patterns, waits a fixed settle time for each, and compares the unit's three
// OR-style responses against their expected values, accumulating a per-pattern
// error count and sticky per-output failure flags.
module gate_response_checker #(
    parameter int unsigned SETTLE_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    input  logic       e,
    input  logic       f,
    input  logic       g,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [2:0] fail_vec,
    output logic [3:0] cur_pattern
);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [3:0] settle_cnt;
    logic [2:0] expected;
    logic [2:0] mismatch;
    logic [4:0] err_next;

    // Expected responses from the driven pattern, and the outcome of this check
    always_comb begin
        expected = {a | b | c | d, c | d, a | b};
        mismatch = {g, f, e} ^ expected;
        err_next = err_count + {4'b0000, |mismatch};
    end

    // Run sequencer: pattern stepping, settle timing, scoring and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            settle_cnt  <= '0;
            cur_pattern <= '0;
            {d, c, b, a} <= '0;
            err_count   <= '0;
            fail_vec    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state        <= DRIVE;
                        cur_pattern  <= '0;
                        {d, c, b, a} <= '0;
                        err_count    <= '0;
                        fail_vec     <= '0;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        pass         <= 1'b0;
                    end
                end
                DRIVE: begin
                    state      <= SETTLE;
                    settle_cnt <= '0;
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                CHECK: begin
                    err_count <= err_next;
                    fail_vec  <= fail_vec | mismatch;
                    if (cur_pattern == 4'hF) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == 5'd0);
                    end else begin
                        state        <= DRIVE;
                        cur_pattern  <= cur_pattern + 4'd1;
                        {d, c, b, a} <= cur_pattern + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_response_checker.sv
// Bench for gate_response_checker: two instances (settle 3 and settle 1), each
// wired to a behavioural gate unit with selectable faults.
module tb_gate_response_checker;

    localparam int S0 = 3;
    localparam int S1 = 1;

    logic       clk;
    logic       rst;
    logic [1:0] start, a, b, c, d, e, f, g, busy, done, pass;
    logic [4:0] err [2];
    logic [2:0] fv  [2];
    logic [3:0] cp  [2];

    // Unit-under-test behaviour: 0 ideal, 1 g stuck 0, 2 e=a&b, 3 ideal^mask, 4 f inverted
    int         mode [2];
    logic [2:0] mask [16];
    logic [3:0] pp;
    logic [2:0] id;
    logic [2:0] rs;

    int total = 0;
    int bad   = 0;

    gate_response_checker #(.SETTLE_CYCLES(S0)) dut (
        .clk(clk), .rst(rst), .start(start[0]),
        .a(a[0]), .b(b[0]), .c(c[0]), .d(d[0]),
        .e(e[0]), .f(f[0]), .g(g[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_count(err[0]), .fail_vec(fv[0]), .cur_pattern(cp[0])
    );

    gate_response_checker #(.SETTLE_CYCLES(S1)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]),
        .a(a[1]), .b(b[1]), .c(c[1]), .d(d[1]),
        .e(e[1]), .f(f[1]), .g(g[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_count(err[1]), .fail_vec(fv[1]), .cur_pattern(cp[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        e = '0; f = '0; g = '0;
        pp = '0; id = '0; rs = '0;
        for (int i = 0; i < 2; i++) begin
            pp = {d[i], c[i], b[i], a[i]};
            id = {|pp, pp[3] | pp[2], pp[1] | pp[0]};
            case (mode[i])
                1:       rs = {1'b0, id[1:0]};
                2:       rs = {id[2], id[1], pp[1] & pp[0]};
                3:       rs = id ^ mask[pp];
                4:       rs = {id[2], ~id[1], id[0]};
                default: rs = id;
            endcase
            e[i] = rs[0];
            f[i] = rs[1];
            g[i] = rs[2];
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Start a run on instance i and count edges from accept to DONE entry
    task automatic run(input int i, input bit hold, output int cycles,
                       output bit busy_ok, output bit pad_ok);
        @(negedge clk);
        start[i] = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start[i] = 1'b0;
        cycles  = 0;
        busy_ok = 1'b1;
        pad_ok  = 1'b1;
        while (!done[i] && cycles < 2000) begin
            if (!busy[i]) busy_ok = 1'b0;
            if ({d[i], c[i], b[i], a[i]} != cp[i]) pad_ok = 1'b0;
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic check_end(input string tag, input int i, input int cycles,
                             input bit busy_ok, input bit pad_ok, input int exp_err,
                             input int exp_fv, input int exp_pass);
        chk({tag, " run_len"}, cycles, 16 * ((i == 0 ? S0 : S1) + 2));
        chk({tag, " busy_during_run"}, int'(busy_ok), 1);
        chk({tag, " pins_track_pattern"}, int'(pad_ok), 1);
        chk({tag, " err_count"}, int'(err[i]), exp_err);
        chk({tag, " fail_vec"}, int'(fv[i]), exp_fv);
        chk({tag, " pass"}, int'(pass[i]), exp_pass);
        chk({tag, " busy_at_done"}, int'(busy[i]), 0);
        chk({tag, " last_pattern"}, int'(cp[i]), 15);
    endtask

    typedef struct {
        int inst;
        int md;
        int exp_err;
        int exp_fv;
        int exp_pass;
    } vec_t;

    initial begin
        vec_t vecs [6];
        int   cycles;
        bit   bok, pok;
        int   n, merr, mfv;

        vecs[0] = '{0, 0, 0,  0, 1};
        vecs[1] = '{0, 1, 15, 4, 0};
        vecs[2] = '{0, 2, 8,  1, 0};
        vecs[3] = '{0, 4, 16, 2, 0};
        vecs[4] = '{1, 0, 0,  0, 1};
        vecs[5] = '{1, 2, 8,  1, 0};

        mode[0] = 0;
        mode[1] = 0;
        for (int p = 0; p < 16; p++) mask[p] = '0;
        start = '0;
        rst   = 1'b1;
        #3;
        for (int i = 0; i < 2; i++) begin
            chk("reset busy", int'(busy[i]), 0);
            chk("reset done", int'(done[i]), 0);
            chk("reset pass", int'(pass[i]), 0);
            chk("reset err", int'(err[i]), 0);
            chk("reset fail_vec", int'(fv[i]), 0);
            chk("reset pattern", int'(cp[i]), 0);
            chk("reset pins", int'({d[i], c[i], b[i], a[i]}), 0);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle without start", int'(busy[0]), 0);

        foreach (vecs[k]) begin
            mode[vecs[k].inst] = vecs[k].md;
            run(vecs[k].inst, 1'b0, cycles, bok, pok);
            check_end($sformatf("vec%0d", k), vecs[k].inst, cycles, bok, pok,
                      vecs[k].exp_err, vecs[k].exp_fv, vecs[k].exp_pass);
        end
        mode[1] = 0;

        // Random fault maps against a pattern-count model
        mode[0] = 3;
        for (int t = 0; t < 6; t++) begin
            merr = 0;
            mfv  = 0;
            for (int p = 0; p < 16; p++) begin
                n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0;
                if (t == 0) n = 0;
                mask[p] = 3'(n);
                if (n != 0) merr++;
                mfv = mfv | n;
            end
            run(0, 1'b0, cycles, bok, pok);
            check_end($sformatf("rand%0d", t), 0, cycles, bok, pok, merr, mfv,
                      (merr == 0) ? 1 : 0);
        end

        // start held high: no restart while busy, restart on first edge in DONE
        mode[0] = 1;
        run(0, 1'b1, cycles, bok, pok);
        check_end("held", 0, cycles, bok, pok, 15, 4, 0);
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        chk("held restart busy", int'(busy[0]), 1);
        chk("held restart done", int'(done[0]), 0);
        chk("held restart pattern", int'(cp[0]), 0);
        chk("held restart err", int'(err[0]), 0);
        chk("held restart fail_vec", int'(fv[0]), 0);
        n = 0;
        while (cp[0] != 4'd7 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reach pattern 7", int'(cp[0]), 7);
        chk("err before reset", int'(err[0]), 6);

        // Reset between edges clears everything without a clock edge
        #2;
        rst = 1'b1;
        #1;
        chk("async rst busy", int'(busy[0]), 0);
        chk("async rst pattern", int'(cp[0]), 0);
        chk("async rst err", int'(err[0]), 0);
        chk("async rst fail_vec", int'(fv[0]), 0);
        chk("async rst pins", int'({d[0], c[0], b[0], a[0]}), 0);
        chk("async rst done", int'(done[0]), 0);
        chk("async rst pass", int'(pass[0]), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("post rst idle busy", int'(busy[0]), 0);
        chk("post rst idle done", int'(done[0]), 0);
        mode[0] = 0;
        run(0, 1'b0, cycles, bok, pok);
        check_end("after_rst", 0, cycles, bok, pok, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
